// File: rtl/reset_seq_pkg.sv
// rtl/reset_seq_pkg.sv - state encoding and counter sizing shared by reset_sequencer
package reset_seq_pkg;

    typedef enum logic [1:0] {
        HOLD     = 2'd0,
        WAIT_ACK = 2'd1,
        DONE     = 2'd2,
        FAULT    = 2'd3
    } seq_state_t;

    // One extra bit over the longest terminal count so the timer can never wrap.
    function automatic int cnt_width(input int hold_cycles, input int timeout_cycles);
        int longest;
        longest = (hold_cycles > timeout_cycles) ? hold_cycles : timeout_cycles;
        return $clog2(longest) + 1;
    endfunction

endpackage

// File: rtl/seq_timer.sv
// rtl/seq_timer.sv - loadable up-counter with clear, increment and terminal-count compare
module seq_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic [W-1:0] tc_val,
    output logic         tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (inc) begin
            cnt <= cnt + W'(1);
        end
    end

    assign tc = (cnt == tc_val);

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - ordered per-stage reset release with ack timeout; RESET_SEQ_AUTO_RETRY_EN retries after a fault
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int STAGES         = 3,
    parameter int HOLD_CYCLES    = 10,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int IDX_W          = (STAGES > 1) ? $clog2(STAGES) : 1
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic [STAGES-1:0] stage_ready,
    output logic [STAGES-1:0] stage_rst,
    output logic              all_ready,
    output logic              fault,
    output logic [IDX_W-1:0]  fault_stage
);

    localparam int                CNT_W      = cnt_width(HOLD_CYCLES, TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  HOLD_TC    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_TC = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(STAGES - 1);
    localparam logic [STAGES-1:0] ALL_ONES   = '1;

    seq_state_t        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [STAGES-1:0] stage_rst_d;
    logic              all_ready_d;
    logic              fault_d;
    logic [IDX_W-1:0]  fault_stage_d;

    logic              tmr_clr, tmr_inc, tmr_tc;
    logic [CNT_W-1:0]  tc_val;
    logic [STAGES-1:0] acked;
    logic              lost;

    seq_timer #(.W(CNT_W)) u_timer (
        .clk      (pclk),
        .rst      (rst),
        .clr      (tmr_clr),
        .load     (1'b0),
        .load_val ('0),
        .inc      (tmr_inc),
        .tc_val   (tc_val),
        .tc       (tmr_tc)
    );

    // Stages already acknowledged must keep their ready high; anything else is a brown-out.
    always_comb begin
        acked = '0;
        for (int j = 0; j < STAGES; j++) begin
            acked[j] = (state_q == DONE) ||
                       ((state_q == WAIT_ACK) && (IDX_W'(j) < idx_q));
        end
    end

    assign lost   = |(acked & ~stage_ready);
    assign tc_val = (state_q == WAIT_ACK) ? TIMEOUT_TC : HOLD_TC;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        stage_rst_d   = stage_rst;
        all_ready_d   = all_ready;
        fault_d       = fault;
        fault_stage_d = fault_stage;
        tmr_clr       = 1'b0;
        tmr_inc       = 1'b0;

        case (state_q)
            HOLD: begin
                if (tmr_tc) begin
                    state_d     = WAIT_ACK;
                    idx_d       = '0;
                    stage_rst_d = stage_rst << 1;
                    tmr_clr     = 1'b1;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            WAIT_ACK: begin
                if (lost) begin
                    state_d     = HOLD;
                    idx_d       = '0;
                    stage_rst_d = ALL_ONES;
                    all_ready_d = 1'b0;
                    tmr_clr     = 1'b1;
                end else if (stage_ready[idx_q]) begin
                    tmr_clr = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d     = DONE;
                        all_ready_d = 1'b1;
                    end else begin
                        // Shifting the mask releases exactly the next stage in order.
                        stage_rst_d = stage_rst << 1;
                        idx_d       = idx_q + IDX_W'(1);
                    end
                end else if (tmr_tc) begin
                    state_d       = FAULT;
                    stage_rst_d   = ALL_ONES;
                    all_ready_d   = 1'b0;
                    fault_d       = 1'b1;
                    fault_stage_d = idx_q;
                    tmr_clr       = 1'b1;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            DONE: begin
                if (lost) begin
                    state_d     = HOLD;
                    idx_d       = '0;
                    stage_rst_d = ALL_ONES;
                    all_ready_d = 1'b0;
                    tmr_clr     = 1'b1;
                end
            end
            FAULT: begin
`ifdef RESET_SEQ_AUTO_RETRY_EN
                if (tmr_tc) begin
                    state_d = HOLD;
                    idx_d   = '0;
                    tmr_clr = 1'b1;
                end else begin
                    tmr_inc = 1'b1;
                end
`else
                tmr_clr = 1'b1;
`endif
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q     <= HOLD;
            idx_q       <= '0;
            stage_rst   <= ALL_ONES;
            all_ready   <= 1'b0;
            fault       <= 1'b0;
            fault_stage <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            stage_rst   <= stage_rst_d;
            all_ready   <= all_ready_d;
            fault       <= fault_d;
            fault_stage <= fault_stage_d;
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - scoreboard bench for reset_sequencer (STAGES=3, HOLD=4, TIMEOUT=8)
module tb_reset_sequencer;

    localparam int STAGES = 3;
    localparam int IDX_W  = 2;

    typedef struct packed {
        logic [2:0] srst;
        logic       ar;
        logic       f;
        logic [1:0] fs;
    } exp_t;

    logic              pclk = 1'b0;
    logic              rst  = 1'b1;
    logic [STAGES-1:0] stage_ready = '0;
    logic [STAGES-1:0] stage_rst;
    logic              all_ready;
    logic              fault;
    logic [IDX_W-1:0]  fault_stage;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc_no     = 0;

    always #5 pclk = ~pclk;

    reset_sequencer #(
        .STAGES         (STAGES),
        .HOLD_CYCLES    (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .pclk        (pclk),
        .rst         (rst),
        .stage_ready (stage_ready),
        .stage_rst   (stage_rst),
        .all_ready   (all_ready),
        .fault       (fault),
        .fault_stage (fault_stage)
    );

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic cyc(input logic r, input logic [2:0] rdy, input logic [2:0] srst,
                       input logic ar, input logic f, input logic [1:0] fs);
        exp_t e;
        @(negedge pclk);
        rst         = r;
        stage_ready = rdy;
        e.srst = srst;
        e.ar   = ar;
        e.f    = f;
        e.fs   = fs;
        exp_q.push_back(e);
    endtask

    task automatic cycn(input int n, input logic r, input logic [2:0] rdy, input logic [2:0] srst,
                        input logic ar, input logic f, input logic [1:0] fs);
        repeat (n) cyc(r, rdy, srst, ar, f, fs);
    endtask

    initial begin : monitor
        exp_t e;
        exp_t a;
        forever begin
            @(posedge pclk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {stage_rst, all_ready, fault, fault_stage};
                compared++;
                if (a !== e) begin
                    mismatched++;
                    $display("FAIL cyc%0d: got stage_rst=%b all_ready=%b fault=%b fault_stage=%0d, need stage_rst=%b all_ready=%b fault=%b fault_stage=%0d",
                             cyc_no, a.srst, a.ar, a.f, a.fs, e.srst, e.ar, e.f, e.fs);
                end
                cyc_no++;
            end
        end
    end

    initial begin : stimulus
        // reset state
        cycn(2, 1, 3'b000, 3'b111, 0, 0, 2'd0);

        // nominal: each ready rises on the third edge after its reset falls
        cycn(3, 0, 3'b000, 3'b111, 0, 0, 2'd0);
        cyc (   0, 3'b000, 3'b110, 0, 0, 2'd0);
        cycn(2, 0, 3'b000, 3'b110, 0, 0, 2'd0);
        cyc (   0, 3'b001, 3'b100, 0, 0, 2'd0);
        cycn(2, 0, 3'b001, 3'b100, 0, 0, 2'd0);
        cyc (   0, 3'b011, 3'b000, 0, 0, 2'd0);
        cycn(2, 0, 3'b011, 3'b000, 0, 0, 2'd0);
        cyc (   0, 3'b111, 3'b000, 1, 0, 2'd0);
        cycn(3, 0, 3'b111, 3'b000, 1, 0, 2'd0);

        // lost ready in DONE restarts with a full hold, no fault
        cyc (   0, 3'b110, 3'b111, 0, 0, 2'd0);
        cycn(3, 0, 3'b000, 3'b111, 0, 0, 2'd0);
        cyc (   0, 3'b000, 3'b110, 0, 0, 2'd0);
        cyc (   0, 3'b001, 3'b100, 0, 0, 2'd0);
        cyc (   0, 3'b011, 3'b000, 0, 0, 2'd0);
        cyc (   0, 3'b111, 3'b000, 1, 0, 2'd0);

        // ready on the same edge as the last-stage timeout wins
        cyc (   1, 3'b000, 3'b111, 0, 0, 2'd0);
        cycn(3, 0, 3'b000, 3'b111, 0, 0, 2'd0);
        cyc (   0, 3'b000, 3'b110, 0, 0, 2'd0);
        cyc (   0, 3'b001, 3'b100, 0, 0, 2'd0);
        cyc (   0, 3'b011, 3'b000, 0, 0, 2'd0);
        cycn(7, 0, 3'b011, 3'b000, 0, 0, 2'd0);
        cyc (   0, 3'b111, 3'b000, 1, 0, 2'd0);
        cyc (   0, 3'b111, 3'b000, 1, 0, 2'd0);

        // stage 1 timeout; readies of stages still in reset are ignored
        cyc (   1, 3'b000, 3'b111, 0, 0, 2'd0);
        cycn(3, 0, 3'b110, 3'b111, 0, 0, 2'd0);
        cyc (   0, 3'b110, 3'b110, 0, 0, 2'd0);
        cyc (   0, 3'b110, 3'b110, 0, 0, 2'd0);
        cyc (   0, 3'b001, 3'b100, 0, 0, 2'd0);
        cycn(7, 0, 3'b001, 3'b100, 0, 0, 2'd0);
        cyc (   0, 3'b001, 3'b111, 0, 1, 2'd1);
`ifdef RESET_SEQ_AUTO_RETRY_EN
        cycn(7, 0, 3'b001, 3'b111, 0, 1, 2'd1);
        cyc (   0, 3'b001, 3'b110, 0, 1, 2'd1);
        cyc (   0, 3'b001, 3'b100, 0, 1, 2'd1);
        cyc (   0, 3'b011, 3'b000, 0, 1, 2'd1);
        cyc (   0, 3'b111, 3'b000, 1, 1, 2'd1);
        cycn(3, 0, 3'b111, 3'b000, 1, 1, 2'd1);
`else
        cycn(25, 0, 3'b001, 3'b111, 0, 1, 2'd1);
        cycn(25, 0, 3'b111, 3'b111, 0, 1, 2'd1);
`endif

        // rst in mid-WAIT_ACK returns everything to reset values
        cyc (   1, 3'b000, 3'b111, 0, 0, 2'd0);
        cycn(3, 0, 3'b000, 3'b111, 0, 0, 2'd0);
        cyc (   0, 3'b000, 3'b110, 0, 0, 2'd0);
        cyc (   0, 3'b001, 3'b100, 0, 0, 2'd0);
        cycn(2, 0, 3'b001, 3'b100, 0, 0, 2'd0);
        cyc (   1, 3'b001, 3'b111, 0, 0, 2'd0);
        cycn(2, 1, 3'b000, 3'b111, 0, 0, 2'd0);

        repeat (3) @(posedge pclk);
        #2;
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d expectations left, need 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: time limit reached, compared=%0d", compared);
        $fatal(1);
    end

endmodule
